led_step_ctrl: RTL and testbench
================================

LED_STEP_CTRL -- requirements
Module: led_step_ctrl

Interface
REQ-001 Parameter BASE_DIV, default 25_000_000, clk cycles per auto-step at period_sel=0; legal range 2..2^22.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500_000, cycles of stable level a button needs (used only with LED_STEP_DEBOUNCE_EN); legal range 1..2^20.
REQ-003 clk  in  1  system clock, all logic rising-edge.
REQ-004 async_nreset  in  1  reset, asynchronous, active-low.
REQ-005 btn_step  in  1  raw manual-step button, active-high, asynchronous to clk.
REQ-006 btn_run  in  1  raw run/stop toggle button, active-high, asynchronous.
REQ-007 btn_lap  in  1  raw single-lap start button, active-high, asynchronous.
REQ-008 period_sel  in  2  auto-step period select: period = BASE_DIV << period_sel cycles.
REQ-009 next_led_re  out  1  one-cycle step pulse to the LED pattern driver.
REQ-010 phase  out  4  current pattern position 0..9, mirrors the driver's state.
REQ-011 mode  out  2  00 IDLE, 01 RUN, 10 LAP.

Function
REQ-012 Each button: 2-flop synchronizer, then rising-edge detect against a third flop; the edge is a one-cycle event.
REQ-013 Without debounce, a raw 0->1 held >=3 cycles yields its event in the cycle after the 3rd rising clk edge; next_led_re, when caused by btn_step, is registered and asserts one cycle after the event.
REQ-014 FSM states IDLE, RUN, LAP; mode encodes the state directly.
REQ-015 IDLE: btn_run event -> RUN; btn_lap event -> LAP; btn_step event -> one next_led_re pulse, stay IDLE.
REQ-016 RUN: btn_run event -> IDLE; btn_lap and btn_step events ignored; timer expiry -> pulse.
REQ-017 LAP: emits timer-driven pulses until phase returns to 0, then -> IDLE in the same cycle as the pulse that sets phase to 0; btn_run event aborts to IDLE; btn_lap/btn_step ignored.
REQ-018 LAP entered with phase=0 emits exactly 10 pulses; entered with phase=k emits 10-k pulses.
REQ-019 Timer: down-counter, 24 bits, loaded with (BASE_DIV<<period_sel)-1 on entry to RUN/LAP and on every expiry; first pulse comes a full period after entry.
REQ-020 period_sel sampled only at timer load; mid-period changes take effect at next reload.
REQ-021 Timer held at reload value in IDLE; no pulses from timer in IDLE.
REQ-022 phase increments mod 10 on every next_led_re pulse (9 -> 0 wrap), independent of source.
REQ-023 next_led_re never high in two consecutive cycles; at most one pulse per cycle regardless of coincident events.
REQ-024 Simultaneous events priority: btn_run > btn_lap > btn_step; lower-priority events in the same cycle are discarded.
REQ-025 State transition and timer expiry in same cycle: transition wins, no pulse emitted.

Reset
REQ-026 async_nreset low: state IDLE, mode=00, phase=0, next_led_re=0, timer at reload value for period_sel=0, all synchronizer/edge/debounce flops 0, immediately and regardless of clk.
REQ-027 Reset mid-LAP or mid-RUN discards progress; no pulse in the first cycle after release.
REQ-028 A button already held high at reset release does not generate an event (edge flop starts at 0 only after sync flops reach 1 together; first event requires observed 0->1 after release).

Configuration
REQ-029 Macro LED_STEP_DEBOUNCE_EN defined: each synchronized button passes through a debouncer whose output changes only after the input has been stable for DEBOUNCE_CYCLES consecutive cycles; edge detect follows the debouncer.
REQ-030 LED_STEP_DEBOUNCE_EN undefined: no debouncer or counter logic synthesized; behaviour per REQ-013.

Verification (BASE_DIV=4, no debounce unless stated)
REQ-031 Reset, btn_step high 5 cycles -> single next_led_re pulse, phase 0->1, mode stays 00.
REQ-032 btn_run pulse, period_sel=0 -> mode=01, pulses every 4 cycles, first 4 cycles after entry; 12 pulses -> phase=2 (wrap verified).
REQ-033 From phase=0 btn_lap -> exactly 10 pulses spaced 4 cycles, phase=0, mode=00; same from phase=7 -> 3 pulses.
REQ-034 In RUN change period_sel 0->2 mid-period -> current interval 4 cycles, following intervals 16.
REQ-035 btn_run, btn_lap, btn_step edges same cycle in IDLE -> mode=01, no pulse; async_nreset low mid-LAP -> phase=0, mode=00 immediately.
REQ-036 With LED_STEP_DEBOUNCE_EN, DEBOUNCE_CYCLES=8: btn_step glitch of 5 cycles -> no pulse; held 12 cycles -> exactly one pulse.

Source files
------------

// File: rtl/led_step_ctrl.sv
// LED pattern step controller: manual step, free-running auto-step and single-lap modes.
// Define LED_STEP_DEBOUNCE_EN to insert a per-button debouncer ahead of the edge detectors.
module led_step_ctrl #(
   parameter int unsigned BASE_DIV        = 25_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
   input  logic       clk,
   input  logic       async_nreset,
   input  logic       btn_step,
   input  logic       btn_run,
   input  logic       btn_lap,
   input  logic [1:0] period_sel,
   output logic       next_led_re,
   output logic [3:0] phase,
   output logic [1:0] mode
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      LAP  = 2'b10
   } state_t;

   localparam logic [23:0] BASE = 24'(BASE_DIV);

   if (BASE_DIV < 2 || BASE_DIV > (32'd1 << 22) ||
       DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (32'd1 << 20)) begin : g_bad_params
      $error("led_step_ctrl: parameter out of legal range");
   end

   // Button bit order: 0 = step, 1 = run, 2 = lap
   logic [2:0] btn_raw;
   logic [2:0] sync1;
   logic [2:0] sync2;
   logic [2:0] lvl;
   logic [2:0] edge_q;
   logic [2:0] armed;
   logic [2:0] btn_ev;
   logic       sampled;

   assign btn_raw = {btn_lap, btn_run, btn_step};

   // armed only sets once sync1 holds a real post-reset low sample, so a
   // button held through reset release never produces an event.
   always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) begin
         sync1   <= '0;
         sync2   <= '0;
         edge_q  <= '0;
         armed   <= '0;
         btn_ev  <= '0;
         sampled <= 1'b0;
      end else begin
         sync1   <= btn_raw;
         sync2   <= sync1;
         edge_q  <= lvl;
         btn_ev  <= lvl & ~edge_q & armed;
         sampled <= 1'b1;
         if (sampled) begin
            armed <= armed | ~sync1;
         end
      end
   end

`ifdef LED_STEP_DEBOUNCE_EN
   localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   for (genvar i = 0; i < 3; i++) begin : g_db
      logic [DB_W-1:0] cnt;
      logic            db;

      always_ff @(posedge clk or negedge async_nreset) begin
         if (!async_nreset) begin
            cnt <= '0;
            db  <= 1'b0;
         end else if (sync2[i] == db) begin
            cnt <= '0;
         end else if (cnt == DB_LAST) begin
            cnt <= '0;
            db  <= sync2[i];
         end else begin
            cnt <= cnt + DB_W'(1);
         end
      end

      assign lvl[i] = db;
   end
`else
   assign lvl = sync2;
`endif

   logic        ev_step;
   logic        ev_run;
   logic        ev_lap;
   logic [23:0] reload;
   logic [23:0] timer;
   logic        expired;
   logic [3:0]  phase_next;
   state_t      state;

   assign ev_step    = btn_ev[0];
   assign ev_run     = btn_ev[1];
   assign ev_lap     = btn_ev[2];
   // Periods beyond 2^24 cycles wrap in the 24-bit timer.
   assign reload     = (BASE << period_sel) - 24'd1;
   assign expired    = (timer == '0);
   assign phase_next = (phase == 4'd9) ? '0 : phase + 4'd1;
   assign mode       = state;

   always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) begin
         state       <= IDLE;
         timer       <= BASE - 24'd1;
         phase       <= '0;
         next_led_re <= 1'b0;
      end else begin
         next_led_re <= 1'b0;
         case (state)
            IDLE: begin
               timer <= reload;
               if (ev_run) begin
                  state <= RUN;
               end else if (ev_lap) begin
                  state <= LAP;
               end else if (ev_step && !next_led_re) begin
                  next_led_re <= 1'b1;
                  phase       <= phase_next;
               end
            end
            RUN: begin
               if (ev_run) begin
                  state <= IDLE;
                  timer <= reload;
               end else if (expired) begin
                  next_led_re <= 1'b1;
                  phase       <= phase_next;
                  timer       <= reload;
               end else begin
                  timer <= timer - 24'd1;
               end
            end
            LAP: begin
               if (ev_run) begin
                  state <= IDLE;
                  timer <= reload;
               end else if (expired) begin
                  next_led_re <= 1'b1;
                  phase       <= phase_next;
                  timer       <= reload;
                  if (phase == 4'd9) begin
                     state <= IDLE;
                  end
               end else begin
                  timer <= timer - 24'd1;
               end
            end
            default: begin
               state <= IDLE;
               timer <= reload;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_step_ctrl.sv
// Bench for led_step_ctrl with BASE_DIV=4: vector table, hand-written corner sequences
// and random stimulus against a cycle-level reference model of the button/step rules.
module tb_led_step_ctrl;

   localparam int unsigned BASE_DIV = 4;
   localparam int unsigned DEB      = 8;

   logic       clk = 1'b0;
   logic       async_nreset = 1'b0;
   logic       btn_step = 1'b0;
   logic       btn_run = 1'b0;
   logic       btn_lap = 1'b0;
   logic [1:0] period_sel = 2'd0;
   logic       next_led_re;
   logic [3:0] phase;
   logic [1:0] mode;

   led_step_ctrl #(.BASE_DIV(BASE_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk(clk), .async_nreset(async_nreset), .btn_step(btn_step), .btn_run(btn_run),
      .btn_lap(btn_lap), .period_sel(period_sel), .next_led_re(next_led_re),
      .phase(phase), .mode(mode)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int pulses_seen = 0;
   bit use_model = 1'b1;

   // Reference model: edge count since reset release, raw samples per edge,
   // and the absolute edge number at which the next timed pulse is due.
   int       m_k, m_mode, m_phase;
   longint   m_due;
   bit       m_pulse;
   bit [4:0] h_st, h_rn, h_lp;

   function automatic void check(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
      end
   endfunction

   task automatic model_reset();
      m_k = 0; m_mode = 0; m_phase = 0; m_pulse = 1'b0; m_due = 0;
      h_st = '0; h_rn = '0; h_lp = '0;
   endtask

   // A press becomes an event 3 edges after the first high sample, and only
   // if the preceding sample was a genuine post-release low.
   function automatic bit press_seen(input bit [4:0] h);
      return (m_k >= 5) && h[3] && !h[4];
   endfunction

   task automatic model_edge(input bit st, input bit rn, input bit lp, input int ps);
      bit e_st, e_rn, e_lp, p;
      int period;
      m_k++;
      h_st = {h_st[3:0], st};
      h_rn = {h_rn[3:0], rn};
      h_lp = {h_lp[3:0], lp};
      e_st = press_seen(h_st);
      e_rn = press_seen(h_rn);
      e_lp = press_seen(h_lp);
      period = BASE_DIV << ps;
      p = 1'b0;
      if (m_mode == 0) begin
         if (e_rn) begin
            m_mode = 1; m_due = m_k + period;
         end else if (e_lp) begin
            m_mode = 2; m_due = m_k + period;
         end else if (e_st && !m_pulse) begin
            p = 1'b1;
         end
      end else if (e_rn) begin
         m_mode = 0;
      end else if (m_k == m_due) begin
         p = 1'b1;
         m_due = m_k + period;
         if (m_mode == 2 && m_phase == 9) m_mode = 0;
      end
      if (p) m_phase = (m_phase + 1) % 10;
      m_pulse = p;
   endtask

   // Inputs change on the falling edge; outputs are checked on the next falling edge.
   task automatic tick(input bit st, input bit rn, input bit lp, input logic [1:0] ps);
      btn_step = st; btn_run = rn; btn_lap = lp; period_sel = ps;
      @(posedge clk);
      if (use_model) model_edge(st, rn, lp, int'(ps));
      @(negedge clk);
      if (use_model) check("cycle{mode,phase,pulse}", {25'd0, mode, phase, next_led_re},
                           m_mode * 32 + m_phase * 2 + int'(m_pulse));
      if (next_led_re) pulses_seen++;
   endtask

   task automatic quiet(input int n, input logic [1:0] ps);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, ps);
   endtask

   task automatic wait_pulse(input int max, input logic [1:0] ps, output int n);
      n = -1;
      for (int i = 1; i <= max; i++) begin
         tick(1'b0, 1'b0, 1'b0, ps);
         if (next_led_re) begin
            n = i;
            return;
         end
      end
   endtask

   typedef struct {
      bit st, rn, lp;
      int n, q;
      int exp_mode, exp_phase, exp_pulses;
   } vec_t;

   vec_t tbl[10];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int iv;
      bit r_st, r_rn, r_lp;
      logic [1:0] r_ps;

      tbl[0] = '{1'b0, 1'b0, 1'b1, 3, 45, 0, 0, 10};  // lap from phase 0
      tbl[1] = '{1'b1, 1'b0, 1'b0, 5,  6, 0, 1,  1};  // manual step
      tbl[2] = '{1'b0, 1'b1, 1'b0, 3, 50, 1, 3, 12};  // run, 12 pulses with wrap
      tbl[3] = '{1'b0, 1'b1, 1'b0, 3,  4, 0, 4,  1};  // stop (one pulse still due)
      tbl[4] = '{1'b1, 1'b0, 1'b0, 5,  6, 0, 5,  1};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 5,  6, 0, 6,  1};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 5,  6, 0, 7,  1};
      tbl[7] = '{1'b0, 1'b0, 1'b1, 3, 20, 0, 0,  3};  // lap from phase 7
      tbl[8] = '{1'b1, 1'b1, 1'b1, 3,  3, 1, 0,  0};  // coincident presses: run wins
      tbl[9] = '{1'b0, 1'b1, 1'b0, 3,  4, 0, 1,  1};

      model_reset();
      #12;
      check("reset_mode", int'(mode), 0);
      check("reset_phase", int'(phase), 0);
      check("reset_pulse", int'(next_led_re), 0);
      @(negedge clk);
      async_nreset = 1'b1;
      quiet(3, 2'd0);

`ifndef LED_STEP_DEBOUNCE_EN
      for (int i = 0; i < 10; i++) begin
         pulses_seen = 0;
         for (int j = 0; j < tbl[i].n; j++) tick(tbl[i].st, tbl[i].rn, tbl[i].lp, 2'd0);
         quiet(tbl[i].q, 2'd0);
         check($sformatf("vec%0d_mode", i), int'(mode), tbl[i].exp_mode);
         check($sformatf("vec%0d_phase", i), int'(phase), tbl[i].exp_phase);
         check($sformatf("vec%0d_pulses", i), pulses_seen, tbl[i].exp_pulses);
      end

      // Period change mid-interval takes effect only at the next reload
      for (int j = 0; j < 3; j++) tick(1'b0, 1'b1, 1'b0, 2'd0);
      wait_pulse(10, 2'd0, iv);
      check("run_first_pulse_seen", int'(iv > 0), 1);
      tick(1'b0, 1'b0, 1'b0, 2'd2);
      wait_pulse(40, 2'd2, iv);
      check("interval_after_change", iv + 1, 4);
      wait_pulse(40, 2'd2, iv);
      check("interval_psel2_a", iv, 16);
      wait_pulse(40, 2'd2, iv);
      check("interval_psel2_b", iv, 16);
      for (int j = 0; j < 3; j++) tick(1'b0, 1'b1, 1'b0, 2'd0);
      quiet(6, 2'd0);
      check("run_stopped_mode", int'(mode), 0);

      // Reset mid-lap, then a button already held at reset release
      for (int j = 0; j < 3; j++) tick(1'b0, 1'b0, 1'b1, 2'd0);
      quiet(12, 2'd0);
      check("lap_in_progress", int'(mode), 2);
      #2 async_nreset = 1'b0;
      #1;
      check("async_reset_mode", int'(mode), 0);
      check("async_reset_phase", int'(phase), 0);
      check("async_reset_pulse", int'(next_led_re), 0);
      btn_step = 1'b1;
      @(negedge clk);
      async_nreset = 1'b1;
      model_reset();
      pulses_seen = 0;
      for (int j = 0; j < 10; j++) tick(1'b1, 1'b0, 1'b0, 2'd0);
      check("held_through_reset_pulses", pulses_seen, 0);
      quiet(4, 2'd0);
      pulses_seen = 0;
      for (int j = 0; j < 4; j++) tick(1'b1, 1'b0, 1'b0, 2'd0);
      quiet(4, 2'd0);
      check("press_after_release_pulses", pulses_seen, 1);

      // Random button activity against the model
      r_st = 1'b0; r_rn = 1'b0; r_lp = 1'b0; r_ps = 2'd0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 3) == 0) r_st = ~r_st;
         if ($urandom_range(0, 11) == 0) r_lp = ~r_lp;
         if ($urandom_range(0, 19) == 0) r_rn = ~r_rn;
         if ($urandom_range(0, 39) == 0) r_ps = 2'($urandom_range(0, 3));
         tick(r_st, r_rn, r_lp, r_ps);
      end
`else
      use_model = 1'b0;
      pulses_seen = 0;
      for (int j = 0; j < 5; j++) tick(1'b1, 1'b0, 1'b0, 2'd0);
      quiet(30, 2'd0);
      check("debounce_glitch_pulses", pulses_seen, 0);
      pulses_seen = 0;
      for (int j = 0; j < 12; j++) tick(1'b1, 1'b0, 1'b0, 2'd0);
      quiet(30, 2'd0);
      check("debounce_held_pulses", pulses_seen, 1);
      check("debounce_phase", int'(phase), 1);
      check("debounce_mode", int'(mode), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
